// File: rtl/writeback_stage.sv
// writeback_stage
//   Registered writeback stage of the in-order RV32I-class core, between the
//   memory stage and the register file. Decodes whether the instruction
//   writes rd, picks the write data (ALU result, aligned/extended load data
//   or PC+4), suppresses writes to x0 and applies stall/flush.
//
// Parameters
//   XLEN        datapath width (32 or 64)
//   REG_ADDR_W  register index width (<= 5); rd = instruction[7 +: REG_ADDR_W]
//
// Ports
//   clk, rst         core clock, synchronous active-high reset
//   in_valid         memory-stage instruction valid
//   stall, flush     hold / kill stage contents (flush wins)
//   instruction      instruction word from memory stage
//   alu_result       ALU output; low 2 bits are the load byte offset
//   load_data        raw aligned word from data memory
//   pc_plus4         link value for JAL/JALR
//   out_valid        stage holds a valid instruction
//   w_en, rd, wdata  register-file write port
//   illegal_load     valid LOAD with reserved funct3
//   retire_count     (WB_RETIRE_CNT_EN only) count of loaded valid instructions
//
// Optional feature macro: WB_RETIRE_CNT_EN

module writeback_stage #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic                  stall,
  input  logic                  flush,
  input  logic [31:0]           instruction,
  input  logic [XLEN-1:0]       alu_result,
  input  logic [31:0]           load_data,
  input  logic [XLEN-1:0]       pc_plus4,
  output logic                  out_valid,
  output logic                  w_en,
  output logic [REG_ADDR_W-1:0] rd,
  output logic [XLEN-1:0]       wdata,
  output logic                  illegal_load
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [31:0]           retire_count
`endif
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_REG   = 7'b0110011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  logic [6:0]            opcode;
  logic [2:0]            funct3;
  logic [1:0]            off;
  logic [REG_ADDR_W-1:0] rd_next;
  logic                  is_load;
  logic                  is_link;
  logic                  writes_rd;
  logic                  illegal_next;
  logic                  w_en_next;
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic [XLEN-1:0]       load_ext;
  logic [XLEN-1:0]       wdata_next;
  logic                  unused_instr_bits;

  assign opcode  = instruction[6:0];
  assign funct3  = instruction[14:12];
  assign off     = alu_result[1:0];
  assign rd_next = instruction[7 +: REG_ADDR_W];

  // Upper instruction bits (and rd bits beyond REG_ADDR_W) are not needed here.
  assign unused_instr_bits = ^{instruction[31:15], instruction[11:7]};

  assign is_load = (opcode == OP_LOAD);
  assign is_link = (opcode == OP_JAL) || (opcode == OP_JALR);

  always_comb begin
    writes_rd = 1'b0;
    case (opcode)
      OP_LOAD, OP_IMM, OP_REG, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: writes_rd = 1'b1;
      default: writes_rd = 1'b0;
    endcase
  end

  // Reserved LOAD funct3 values: 011 (LD on RV32), 110, 111.
  assign illegal_next = in_valid && is_load &&
                        ((funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111));

  assign w_en_next = in_valid && writes_rd && (rd_next != '0) && !illegal_next;

  always_comb begin
    ld_byte = load_data[7:0];
    case (off)
      2'd0: ld_byte = load_data[7:0];
      2'd1: ld_byte = load_data[15:8];
      2'd2: ld_byte = load_data[23:16];
      2'd3: ld_byte = load_data[31:24];
      default: ld_byte = load_data[7:0];
    endcase
  end

  // Halfword select ignores off[0]; misalignment is trapped upstream, not here.
  assign ld_half = off[1] ? load_data[31:16] : load_data[15:0];

  // Size casts of signed operands sign-extend, unsigned ones zero-extend.
  // Reserved funct3 returns zero; the write is suppressed anyway.
  always_comb begin
    load_ext = '0;
    case (funct3)
      3'b000:  load_ext = XLEN'($signed(ld_byte));
      3'b100:  load_ext = XLEN'(ld_byte);
      3'b001:  load_ext = XLEN'($signed(ld_half));
      3'b101:  load_ext = XLEN'(ld_half);
      3'b010:  load_ext = XLEN'($signed(load_data));
      default: load_ext = '0;
    endcase
  end

  always_comb begin
    wdata_next = alu_result;
    if (is_load)
      wdata_next = load_ext;
    else if (is_link)
      wdata_next = pc_plus4;
  end

  // rd and wdata load even when the write is suppressed; only the qualifiers
  // (out_valid, w_en, illegal_load) are cleared by flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid    <= 1'b0;
      w_en         <= 1'b0;
      rd           <= '0;
      wdata        <= '0;
      illegal_load <= 1'b0;
    end else if (flush) begin
      out_valid    <= 1'b0;
      w_en         <= 1'b0;
      illegal_load <= 1'b0;
    end else if (!stall) begin
      out_valid    <= in_valid;
      w_en         <= w_en_next;
      rd           <= rd_next;
      wdata        <= wdata_next;
      illegal_load <= illegal_next;
    end
  end

`ifdef WB_RETIRE_CNT_EN
  // Counts every valid instruction accepted into the stage, writing or not.
  always_ff @(posedge clk) begin
    if (rst)
      retire_count <= '0;
    else if (!flush && !stall && in_valid)
      retire_count <= retire_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_writeback_stage.sv
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        rst, in_valid, stall, flush;
  logic [31:0] instruction, alu_result, load_data, pc_plus4;
  logic        out_valid, w_en, illegal_load;
  logic [4:0]  rd;
  logic [31:0] wdata;
`ifdef WB_RETIRE_CNT_EN
  logic [31:0] retire_count;
`endif

  writeback_stage #(.XLEN(32), .REG_ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall), .flush(flush),
    .instruction(instruction), .alu_result(alu_result), .load_data(load_data),
    .pc_plus4(pc_plus4), .out_valid(out_valid), .w_en(w_en), .rd(rd),
    .wdata(wdata), .illegal_load(illegal_load)
`ifdef WB_RETIRE_CNT_EN
    , .retire_count(retire_count)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  logic        exp_valid, exp_wen, exp_ill;
  logic [4:0]  exp_rd;
  logic [31:0] exp_wdata;
  longint      exp_cnt;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] alu;
    logic [31:0] ld;
    logic [31:0] pc;
    logic        e_wen;
    logic [4:0]  e_rd;
    logic [31:0] e_wdata;
    logic        e_ill;
  } vec_t;

  function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] r, input logic [2:0] f3);
    return {17'd0, f3, r, op};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural decode straight from the instruction-set rules.
  function automatic void ref_decode(input logic [31:0] ins, input logic [31:0] alu,
                                     input logic [31:0] ld, input logic [31:0] pc, input logic v,
                                     output logic w, output logic [4:0] r,
                                     output logic [31:0] d, output logic il);
    int unsigned op, f3, off;
    longint unsigned val;
    bit writes;
    op  = ins[6:0];
    f3  = ins[14:12];
    r   = ins[11:7];
    off = alu % 4;
    writes = (op == 'h03) || (op == 'h13) || (op == 'h33) || (op == 'h37) ||
             (op == 'h17) || (op == 'h6F) || (op == 'h67);
    il = v && (op == 'h03) && (f3 == 3 || f3 == 6 || f3 == 7);
    if (op == 'h03) begin
      val = 0;
      if (f3 == 0 || f3 == 4) begin
        val = (longint'(ld) >> (8 * off)) % 256;
        if (f3 == 0 && val >= 128) val = val + 64'hFFFF_FF00;
      end else if (f3 == 1 || f3 == 5) begin
        val = (longint'(ld) >> (16 * (off / 2))) % 65536;
        if (f3 == 1 && val >= 32768) val = val + 64'hFFFF_0000;
      end else if (f3 == 2) begin
        val = ld;
      end
      d = val[31:0];
    end else if (op == 'h6F || op == 'h67) begin
      d = pc;
    end else begin
      d = alu;
    end
    w = v && writes && (r != 0) && !il;
  endfunction

  // Advance the model with the current inputs, then clock the DUT.
  task automatic step();
    logic w, il;
    logic [4:0] r;
    logic [31:0] d;
    ref_decode(instruction, alu_result, load_data, pc_plus4, in_valid, w, r, d, il);
    if (rst) begin
      exp_valid = 0; exp_wen = 0; exp_rd = 0; exp_wdata = 0; exp_ill = 0; exp_cnt = 0;
    end else if (flush) begin
      exp_valid = 0; exp_wen = 0; exp_ill = 0;
    end else if (!stall) begin
      exp_valid = in_valid; exp_wen = w; exp_rd = r; exp_wdata = d; exp_ill = il;
      if (in_valid) exp_cnt = (exp_cnt + 1) % 64'h1_0000_0000;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_model(input string nm);
    chk({nm, "_valid"}, out_valid, exp_valid);
    chk({nm, "_wen"}, w_en, exp_wen);
    chk({nm, "_rd"}, rd, exp_rd);
    chk({nm, "_wdata"}, wdata, exp_wdata);
    chk({nm, "_ill"}, illegal_load, exp_ill);
`ifdef WB_RETIRE_CNT_EN
    chk({nm, "_cnt"}, retire_count, exp_cnt[31:0]);
`endif
  endtask

  task automatic drive(input logic [31:0] ins, input logic [31:0] alu,
                       input logic [31:0] ld, input logic [31:0] pc);
    instruction = ins; alu_result = alu; load_data = ld; pc_plus4 = pc;
  endtask

  localparam logic [6:0] OPS [10] = '{7'h03, 7'h13, 7'h33, 7'h37, 7'h17,
                                      7'h6F, 7'h67, 7'h63, 7'h23, 7'h73};

  vec_t vecs [15];

  initial begin
    vecs[0]  = '{mk(7'h33, 7, 0), 32'h1234, 32'h0, 32'h0, 1'b1, 5'd7, 32'h0000_1234, 1'b0};
    vecs[1]  = '{mk(7'h33, 0, 0), 32'h1234, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0000_1234, 1'b0};
    vecs[2]  = '{mk(7'h03, 10, 3'b000), 32'h3, 32'h80FF7F01, 32'h0, 1'b1, 5'd10, 32'hFFFF_FF80, 1'b0};
    vecs[3]  = '{mk(7'h03, 11, 3'b100), 32'h3, 32'h80FF7F01, 32'h0, 1'b1, 5'd11, 32'h0000_0080, 1'b0};
    vecs[4]  = '{mk(7'h03, 12, 3'b001), 32'h2, 32'h80FF7F01, 32'h0, 1'b1, 5'd12, 32'hFFFF_80FF, 1'b0};
    vecs[5]  = '{mk(7'h03, 13, 3'b101), 32'h0, 32'h80FF7F01, 32'h0, 1'b1, 5'd13, 32'h0000_7F01, 1'b0};
    vecs[6]  = '{mk(7'h6F, 1, 0), 32'h77, 32'h0, 32'h104, 1'b1, 5'd1, 32'h0000_0104, 1'b0};
    vecs[7]  = '{mk(7'h63, 3, 0), 32'h55, 32'h0, 32'h200, 1'b0, 5'd3, 32'h0000_0055, 1'b0};
    vecs[8]  = '{mk(7'h03, 4, 3'b110), 32'h0, 32'h1111_2222, 32'h0, 1'b0, 5'd4, 32'h0, 1'b1};
    vecs[9]  = '{mk(7'h03, 9, 3'b010), 32'h0, 32'hDEAD_BEEF, 32'h0, 1'b1, 5'd9, 32'hDEAD_BEEF, 1'b0};
    vecs[10] = '{mk(7'h37, 2, 0), 32'hABCD_E000, 32'h0, 32'h0, 1'b1, 5'd2, 32'hABCD_E000, 1'b0};
    vecs[11] = '{mk(7'h03, 14, 3'b001), 32'h3, 32'h80FF7F01, 32'h0, 1'b1, 5'd14, 32'hFFFF_80FF, 1'b0};
    vecs[12] = '{mk(7'h67, 31, 0), 32'h9, 32'h0, 32'h2000, 1'b1, 5'd31, 32'h0000_2000, 1'b0};
    vecs[13] = '{mk(7'h03, 0, 3'b111), 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1};
    vecs[14] = '{mk(7'h17, 6, 0), 32'h1000_0040, 32'h0, 32'h0, 1'b1, 5'd6, 32'h1000_0040, 1'b0};

    rst = 1; in_valid = 1; stall = 0; flush = 0;
    drive(mk(7'h13, 5, 0), 32'h5, 32'h0, 32'h0);
    exp_valid = 0; exp_wen = 0; exp_rd = 0; exp_wdata = 0; exp_ill = 0; exp_cnt = 0;

    // reset held two cycles with a valid ADDI x5 present
    for (int i = 0; i < 2; i++) begin
      step();
      chk("rst_valid", out_valid, 1'b0);
      chk("rst_wen", w_en, 1'b0);
      chk("rst_wdata", wdata, 32'h0);
      chk("rst_ill", illegal_load, 1'b0);
    end
    rst = 0;
    step();
    chk("post_rst_wen", w_en, 1'b1);
    chk("post_rst_rd", rd, 5'd5);

    // table vectors, back to back
    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].instr, vecs[i].alu, vecs[i].ld, vecs[i].pc);
      in_valid = 1;
      step();
      chk($sformatf("vec%0d_valid", i), out_valid, 1'b1);
      chk($sformatf("vec%0d_wen", i), w_en, vecs[i].e_wen);
      chk($sformatf("vec%0d_rd", i), rd, vecs[i].e_rd);
      chk($sformatf("vec%0d_wdata", i), wdata, vecs[i].e_wdata);
      chk($sformatf("vec%0d_ill", i), illegal_load, vecs[i].e_ill);
    end

    // illegal_load lasts one cycle when followed by an idle slot
    drive(mk(7'h03, 4, 3'b110), 32'h0, 32'h0, 32'h0);
    step();
    chk("ill_pulse_hi", illegal_load, 1'b1);
    in_valid = 0;
    step();
    chk("ill_pulse_lo", illegal_load, 1'b0);
    chk("idle_valid", out_valid, 1'b0);
    chk("idle_wen", w_en, 1'b0);

    // stall for three cycles while new instructions arrive
    in_valid = 1;
    drive(mk(7'h33, 7, 0), 32'h1234, 32'h0, 32'h0);
    step();
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      drive(mk(7'h13, 5'(20 + i), 0), 32'h9999_0000 + 32'(i), 32'h0, 32'h0);
      step();
      chk("stall_valid", out_valid, 1'b1);
      chk("stall_wen", w_en, 1'b1);
      chk("stall_rd", rd, 5'd7);
      chk("stall_wdata", wdata, 32'h1234);
    end
    // flush together with stall: flush wins, rd/wdata hold
    flush = 1;
    step();
    chk("flush_stall_valid", out_valid, 1'b0);
    chk("flush_stall_wen", w_en, 1'b0);
    chk("flush_stall_rd", rd, 5'd7);
    chk("flush_stall_wdata", wdata, 32'h1234);
    flush = 0;

    // reset while stalled clears everything
    rst = 1;
    step();
    chk_model("rst_in_stall");
    chk("rst_in_stall_rd", rd, 5'd0);
    rst = 0; stall = 0;

`ifdef WB_RETIRE_CNT_EN
    // five valid instructions with one stalled cycle in between
    for (int i = 0; i < 6; i++) begin
      in_valid = 1;
      stall = (i == 2);
      drive(mk(7'h13, 5'(i + 1), 0), 32'(i), 32'h0, 32'h0);
      step();
    end
    stall = 0;
    chk("retire_five", retire_count, 32'd5);
`endif

    // randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      rst      = ($urandom_range(0, 63) == 0);
      flush    = ($urandom_range(0, 9) == 0);
      stall    = ($urandom_range(0, 5) == 0);
      in_valid = ($urandom_range(0, 3) != 0);
      begin
        logic [31:0] ins;
        ins = $urandom;
        ins[6:0] = OPS[$urandom_range(0, 9)];
        if ($urandom_range(0, 7) == 0) ins[11:7] = 5'd0;
        drive(ins, $urandom, $urandom, $urandom);
      end
      step();
      chk_model("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
